// File: rtl/frame_counter_if.sv
// Register-side and strobe-side signals of the APU frame sequencer.
// The CPU side drives through master; the sequencer uses slave.
interface frame_counter_if;
    logic [7:0] reg_4017;
    logic       reg_event;
    logic       status_read;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       frame_irq;
    logic [2:0] frame_step;

    modport master (
        output reg_4017, reg_event, status_read,
        input  enable_240hz, enable_120hz, frame_irq, frame_step
    );

    modport slave (
        input  reg_4017, reg_event, status_read,
        output enable_240hz, enable_120hz, frame_irq, frame_step
    );
endinterface

// File: rtl/frame_counter.sv
// APU frame sequencer: turns the APU clock into quarter-frame / half-frame
// strobes and the 4-step frame interrupt, programmed through $4017.
module frame_counter #(
    parameter int unsigned STEP_CYCLES = 7457
) (
    input  logic            clk,
    input  logic            rst,
    frame_counter_if.slave  bus
);
    typedef enum logic [2:0] {STEP0, STEP1, STEP2, STEP3, STEP4} step_e;

    localparam logic [15:0] LAST = 16'(STEP_CYCLES - 1);

    logic [15:0] divider;
    step_e       step, step_nxt;
    logic        mode_5, inhibit;
    logic        q_r, h_r, irq_r;
    logic        q_nxt, h_nxt, irq_set;
    logic        terminal;

    // Only the mode and inhibit bits of $4017 matter here.
    logic unused_bits;
    assign unused_bits = ^bus.reg_4017[5:0];

    assign terminal = (divider == LAST);

    // State register.
    // NOTE: every sequential block uses non-blocking assignments so all registers
    // see the pre-edge values of their neighbours, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) step <= STEP0;
        else     step <= step_nxt;
    end

    // Next-state: a $4017 write restarts the sequence and discards any pending step.
    always_comb begin
        step_nxt = step;
        if (bus.reg_event) begin
            step_nxt = STEP0;
        end else if (terminal) begin
            case (step)
                STEP0:   step_nxt = STEP1;
                STEP1:   step_nxt = STEP2;
                STEP2:   step_nxt = STEP3;
                STEP3:   step_nxt = mode_5 ? STEP4 : STEP0;
                default: step_nxt = STEP0;
            endcase
        end
    end

    // Output decode: strobes to be registered on this edge.
    // NOTE: all outputs get a default first so no path leaves them unassigned (no latches).
    always_comb begin
        q_nxt   = 1'b0;
        h_nxt   = 1'b0;
        irq_set = 1'b0;
        if (bus.reg_event) begin
            // Switching into 5-step mode clocks a quarter and half frame at once.
            q_nxt = bus.reg_4017[7];
            h_nxt = bus.reg_4017[7];
        end else if (terminal) begin
            case (step)
                STEP0, STEP2: q_nxt = 1'b1;
                STEP1, STEP4: begin
                    q_nxt = 1'b1;
                    h_nxt = 1'b1;
                end
                STEP3: if (!mode_5) begin
                    q_nxt   = 1'b1;
                    h_nxt   = 1'b1;
                    irq_set = !inhibit;
                end
                default: ;
            endcase
        end
    end

    // Divider, programmed mode bits and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divider <= '0;
            mode_5  <= 1'b0;
            inhibit <= 1'b0;
            q_r     <= 1'b0;
            h_r     <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            q_r <= q_nxt;
            h_r <= h_nxt;
            if (bus.reg_event) begin
                mode_5  <= bus.reg_4017[7];
                inhibit <= bus.reg_4017[6];
                divider <= '0;
            end else if (terminal) begin
                divider <= '0;
            end else begin
                divider <= divider + 16'd1;
            end
            // Inhibit write clears first, then a step-3 set, then a status read.
            if (bus.reg_event && bus.reg_4017[6]) irq_r <= 1'b0;
            else if (irq_set)                     irq_r <= 1'b1;
            else if (bus.status_read)             irq_r <= 1'b0;
        end
    end

    assign bus.enable_240hz = q_r;
    assign bus.enable_120hz = h_r;
    assign bus.frame_irq    = irq_r;
    assign bus.frame_step   = step;
endmodule

// File: tb/tb_frame_counter.sv
// Directed and random stimulus for frame_counter, checked against a model that
// derives every expected output from edge counts since the last restart.
module tb_frame_counter;
    localparam int SC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_counter_if bus();

    frame_counter #(.STEP_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: edges since the last restart plus programmed bits.
    int t;
    bit m_mode, m_inh, m_irq, m_q, m_h;

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_q = 0; m_h = 0;
    endtask

    task automatic model_edge(bit ev, logic [7:0] d, bit sr);
        int n, s;
        bit set;
        set = 0;
        if (ev) begin
            m_mode = d[7];
            m_inh  = d[6];
            t      = 0;
            m_q    = m_mode;
            m_h    = m_mode;
        end else begin
            t++;
            m_q = 0;
            m_h = 0;
            if (t % SC == 0) begin
                n = t / SC;
                s = (n - 1) % (m_mode ? 5 : 4);
                if (!m_mode) begin
                    m_q = 1;
                    m_h = (s == 1 || s == 3);
                    set = (s == 3) && !m_inh;
                end else begin
                    m_q = (s != 3);
                    m_h = (s == 1 || s == 4);
                end
            end
        end
        if (ev && m_inh) m_irq = 0;
        else if (set)    m_irq = 1;
        else if (sr)     m_irq = 0;
    endtask

    function automatic logic [7:0] exp_step();
        return 8'((t / SC) % (m_mode ? 5 : 4));
    endfunction

    task automatic check_all(string tag);
        check({tag, ".q"},    8'(bus.enable_240hz), 8'(m_q));
        check({tag, ".h"},    8'(bus.enable_120hz), 8'(m_h));
        check({tag, ".irq"},  8'(bus.frame_irq),    8'(m_irq));
        check({tag, ".step"}, 8'(bus.frame_step),   exp_step());
    endtask

    task automatic tick(string tag, bit ev = 0, logic [7:0] d = 8'h00, bit sr = 0);
        bus.reg_event   = ev;
        bus.reg_4017    = d;
        bus.status_read = sr;
        @(posedge clk);
        model_edge(ev, d, sr);
        #2;
        check_all(tag);
        bus.reg_event   = 1'b0;
        bus.status_read = 1'b0;
    endtask

    task automatic run(string tag, int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic timeout(string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    initial begin
        bit found;
        bus.reg_4017    = 8'h00;
        bus.reg_event   = 1'b0;
        bus.status_read = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_all("reset");
        rst = 1'b0;

        // 1: free-running 4-step sequence, IRQ at 32 held through 64
        run("t1", 64);
        check("t1.irq_held", 8'(bus.frame_irq), 8'd1);

        // 2: inhibit write clears IRQ, no new set
        tick("t2.wr", 1, 8'h40);
        check("t2.irq_clr", 8'(bus.frame_irq), 8'd0);
        run("t2", 40);

        // 3: 5-step mode, immediate Q+H
        tick("t3.wr", 1, 8'h80);
        check("t3.q_now", 8'(bus.enable_240hz), 8'd1);
        check("t3.h_now", 8'(bus.enable_120hz), 8'd1);
        run("t3", 90);

        // 4: status_read against a step-3 IRQ set
        tick("t4.wr", 1, 8'h00);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if ((t + 1) % (4 * SC) == 0) begin found = 1; break; end
            tick("t4.wait");
        end
        if (!found) timeout("t4.align");
        tick("t4.sr_set", 0, 8'h00, 1);
        check("t4.irq_wins", 8'(bus.frame_irq), 8'd1);
        tick("t4.sr_clr", 0, 8'h00, 1);
        check("t4.irq_read", 8'(bus.frame_irq), 8'd0);

        // 5: write on a terminal edge discards that step
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if ((t + 1) % SC == 0) begin found = 1; break; end
            tick("t5.wait");
        end
        if (!found) timeout("t5.align");
        tick("t5.wr", 1, 8'h00);
        check("t5.no_q", 8'(bus.enable_240hz), 8'd0);
        check("t5.step0", 8'(bus.frame_step), 8'd0);
        run("t5", 10);

        // 6: async reset mid-step with IRQ pending
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_irq) begin found = 1; break; end
            tick("t6.wait");
        end
        if (!found) timeout("t6.irq");
        run("t6.mid", 3);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        @(posedge clk);
        #2;
        rst = 1'b0;
        run("t6.after", 20);

        // Random writes and status reads
        for (int i = 0; i < 2000; i++) begin
            bit ev, sr;
            logic [7:0] d;
            ev = ($urandom_range(0, 39) == 0);
            sr = ($urandom_range(0, 9) == 0);
            d  = 8'($urandom);
            tick("rand", ev, d, sr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
